// File: rtl/rvee_exec_md.sv
// rvee_exec_md: RVee execute stage with single-cycle ALU and iterative RV32M/RV64M multiply/divide.
module rvee_exec_md #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1,
  parameter int DIV_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dec_valid,
  output logic            dec_ready,
  input  logic [XLEN-1:0] dec_pc,
  input  logic [4:0]      dec_op,
  input  logic [XLEN-1:0] dec_a,
  input  logic [XLEN-1:0] dec_b,
  input  logic [4:0]      dec_rd,
  input  logic            dec_rd_we,
  input  logic            dec_bcc,
  input  logic            dec_bcc_n,
  input  logic            mem_exception,
  output logic            ex_valid,
  input  logic            ex_done,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we,
  output logic [XLEN-1:0] ex_result,
  output logic            bcc_taken,
  output logic            busy
);
  localparam int SW = $clog2(XLEN);
  localparam int CW = $clog2(XLEN + 1);
  localparam logic [CW-1:0] MUL_N = CW'(XLEN / MUL_BITS);
  localparam logic [CW-1:0] DIV_N = CW'(XLEN / DIV_BITS);
  typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;
  state_t r_state, w_state_nxt;
  logic              r_ex_valid, r_ex_rd_we, r_bcc, r_bcc_n;
  logic [XLEN-1:0]   r_ex_pc, r_ex_result;
  logic [4:0]        r_ex_rd;
  logic [2*XLEN-1:0] r_p;
  logic [XLEN-1:0]   r_m, r_pc;
  logic [CW-1:0]     r_cnt;
  logic              r_nq, r_nr, r_div, r_rd_we;
  logic [1:0]        r_sel;
  logic [4:0]        r_rd;
  logic              w_accept, w_flush, w_is_m, w_is_div, w_m_go;
  logic              w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_div0, w_ovf, w_special;
  logic [XLEN-1:0]   w_a_mag, w_b_mag, w_alu, w_quo, w_rem, w_fix;
  logic [SW-1:0]     w_sh;
  logic [XLEN+MUL_BITS-1:0]   w_sum;
  logic [2*XLEN+MUL_BITS-1:0] w_cat;
  logic [2*XLEN-1:0] w_mul_nxt, w_prod;
  logic [XLEN:0]     w_dt;
  logic [XLEN-1:0]   w_dr, w_dq;
  logic              w_ge;
  assign w_flush  = bcc_taken | mem_exception;
  assign w_accept = dec_valid & dec_ready;
  assign w_is_m   = dec_op[4:3] == 2'b10;
  assign w_is_div = dec_op[2];
  assign w_m_go   = w_accept & w_is_m & !w_flush;
  assign w_sh     = dec_b[SW-1:0];
  always_comb begin
    case (dec_op)
      5'd0:    w_alu = dec_a + dec_b;
      5'd1:    w_alu = dec_a - dec_b;
      5'd2:    w_alu = dec_a & dec_b;
      5'd3:    w_alu = dec_a | dec_b;
      5'd4:    w_alu = dec_a ^ dec_b;
      5'd5:    w_alu = dec_a << w_sh;
      5'd6:    w_alu = dec_a >> w_sh;
      5'd7:    w_alu = $unsigned($signed(dec_a) >>> w_sh);
      5'd8:    w_alu = {{(XLEN-1){1'b0}}, $signed(dec_a) < $signed(dec_b)};
      5'd9:    w_alu = {{(XLEN-1){1'b0}}, dec_a < dec_b};
      default: w_alu = '0;
    endcase
  end
  // MULH/MULHSU and DIV/REM see a signed A; only MULH and DIV/REM see a signed B
  assign w_a_sgn   = w_is_div ? !dec_op[0] : (dec_op[1:0] == 2'd1 || dec_op[1:0] == 2'd2);
  assign w_b_sgn   = w_is_div ? !dec_op[0] : (dec_op[1:0] == 2'd1);
  assign w_a_neg   = w_a_sgn & dec_a[XLEN-1];
  assign w_b_neg   = w_b_sgn & dec_b[XLEN-1];
  assign w_a_mag   = w_a_neg ? -dec_a : dec_a;
  assign w_b_mag   = w_b_neg ? -dec_b : dec_b;
  assign w_div0    = dec_b == '0;
  assign w_ovf     = !dec_op[0] && dec_a == {1'b1, {(XLEN-1){1'b0}}} && (&dec_b);
  assign w_special = w_is_div & (w_div0 | w_ovf);
  assign w_sum     = {{MUL_BITS{1'b0}}, r_p[2*XLEN-1:XLEN]}
                   + ({{MUL_BITS{1'b0}}, r_m} * {{XLEN{1'b0}}, r_p[MUL_BITS-1:0]});
  assign w_cat     = {w_sum, r_p[XLEN-1:0]};
  assign w_mul_nxt = w_cat[2*XLEN+MUL_BITS-1:MUL_BITS];
  always_comb begin
    w_dr = r_p[2*XLEN-1:XLEN];
    w_dq = r_p[XLEN-1:0];
    w_dt = '0;
    w_ge = 1'b0;
    for (int i = 0; i < DIV_BITS; i++) begin
      w_dt = {w_dr, w_dq[XLEN-1]};
      w_ge = w_dt >= {1'b0, r_m};
      w_dr = w_ge ? w_dt[XLEN-1:0] - r_m : w_dt[XLEN-1:0];
      w_dq = {w_dq[XLEN-2:0], w_ge};
    end
  end
  assign w_prod = r_nq ? -r_p : r_p;
  assign w_quo  = r_nq ? -r_p[XLEN-1:0] : r_p[XLEN-1:0];
  assign w_rem  = r_nr ? -r_p[2*XLEN-1:XLEN] : r_p[2*XLEN-1:XLEN];
  assign w_fix  = r_div ? (r_sel[1] ? w_rem : w_quo)
                        : (r_sel == 2'd0 ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_state_nxt;
  always_comb begin
    case (r_state)
      IDLE:    w_state_nxt = w_m_go ? (w_special ? FIX : BUSY) : IDLE;
      BUSY:    w_state_nxt = mem_exception ? IDLE : (r_cnt == CW'(1) ? FIX : BUSY);
      default: w_state_nxt = IDLE;
    endcase
  end
  always_comb begin
    busy      = r_state != IDLE;
    dec_ready = (r_state == IDLE) & (!r_ex_valid | ex_done);
  end
  // Special divides preload the final quotient/remainder and skip sign correction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_m_go) begin
      r_p     <= w_special ? (w_div0 ? {dec_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, dec_a})
                           : {{XLEN{1'b0}}, w_is_div ? w_a_mag : w_b_mag};
      r_m     <= w_is_div ? w_b_mag : w_a_mag;
      r_nq    <= !w_special & (w_a_neg ^ w_b_neg);
      r_nr    <= !w_special & w_a_neg;
      r_div   <= w_is_div;
      r_sel   <= dec_op[1:0];
      r_pc    <= dec_pc;
      r_rd    <= dec_rd;
      r_rd_we <= dec_rd_we;
      r_cnt   <= w_is_div ? DIV_N : MUL_N;
    end else if (r_state == BUSY) begin
      r_p   <= r_div ? {w_dr, w_dq} : w_mul_nxt;
      r_cnt <= r_cnt - CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid  <= 1'b0;
      r_ex_rd_we  <= 1'b0;
      r_ex_pc     <= '0;
      r_ex_rd     <= '0;
      r_ex_result <= '0;
    end else if (w_accept && !w_is_m) begin
      r_ex_valid  <= !w_flush;
      r_ex_rd_we  <= dec_rd_we & !w_flush;
      r_ex_pc     <= dec_pc;
      r_ex_rd     <= dec_rd;
      r_ex_result <= w_alu;
    end else if (w_accept) begin
      r_ex_valid  <= 1'b0;
    end else if (r_state == FIX && !mem_exception) begin
      r_ex_valid  <= 1'b1;
      r_ex_rd_we  <= r_rd_we;
      r_ex_pc     <= r_pc;
      r_ex_rd     <= r_rd;
      r_ex_result <= w_fix;
    end else if (ex_done) begin
      r_ex_valid  <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcc   <= 1'b0;
      r_bcc_n <= 1'b0;
    end else begin
      r_bcc   <= w_accept & dec_bcc & !w_flush;
      r_bcc_n <= w_accept & dec_bcc_n;
    end
  end
  assign bcc_taken = r_bcc & (r_bcc_n ^ (r_ex_result == '0));
  assign ex_valid  = r_ex_valid;
  assign ex_rd_we  = r_ex_rd_we;
  assign ex_pc     = r_ex_pc;
  assign ex_rd     = r_ex_rd;
  assign ex_result = r_ex_result;
endmodule
